// File: rtl/imem_pkg.sv
// Shared types and default widths for the instruction-memory arbiter.
package imem_pkg;

    localparam int N_DEFAULT = 32;
    localparam int A_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_grant.sv
// Combinational grant and next-state logic for the two-requester imem arbiter.
//
// state | meaning
// IDLE  | nothing granted last cycle; a tie goes to the requester that was not served last
// OWN0  | fetch requester was granted last cycle; it keeps the port until its burst is used up
// OWN1  | debug/loader requester was granted last cycle; same burst rule
module arb_grant
    import imem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  arb_state_t state,
    input  logic       last,
    input  logic [3:0] cnt,
    input  logic       v0,
    input  logic       v1,
    output logic       gnt0,
    output logic       gnt1,
    output arb_state_t state_nxt,
    output logic [3:0] cnt_nxt,
    output logic       last_nxt
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    // Pick a winner. If the owner is alone, its burst count restarts, so it is never stalled.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
        last_nxt  = last;
        case (state)
            OWN0: begin
                if (v0 && (cnt < MAX_CNT)) begin
                    gnt0    = 1'b1;
                    cnt_nxt = cnt + 4'd1;
                end else if (v1) begin
                    gnt1    = 1'b1;
                    cnt_nxt = 4'd1;
                end else if (v0) begin
                    gnt0    = 1'b1;
                    cnt_nxt = 4'd1;
                end
            end
            OWN1: begin
                if (v1 && (cnt < MAX_CNT)) begin
                    gnt1    = 1'b1;
                    cnt_nxt = cnt + 4'd1;
                end else if (v0) begin
                    gnt0    = 1'b1;
                    cnt_nxt = 4'd1;
                end else if (v1) begin
                    gnt1    = 1'b1;
                    cnt_nxt = 4'd1;
                end
            end
            default: begin
                if (v0 && (!v1 || last)) begin
                    gnt0    = 1'b1;
                    cnt_nxt = 4'd1;
                end else if (v1) begin
                    gnt1    = 1'b1;
                    cnt_nxt = 4'd1;
                end
            end
        endcase
        if (gnt0) begin
            state_nxt = OWN0;
            last_nxt  = 1'b0;
        end else if (gnt1) begin
            state_nxt = OWN1;
            last_nxt  = 1'b1;
        end
    end

endmodule

// File: rtl/imem_arb.sv
// Two-port arbiter in front of a combinational-read instruction ROM.
// Read data is registered, so each response follows its grant by one cycle.
module imem_arb
    import imem_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int A         = A_DEFAULT,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [A-1:0] req0_addr,
    output logic         req0_ready,
    output logic         rsp0_valid,
    output logic [N-1:0] rsp0_data,
    input  logic         req1_valid,
    input  logic [A-1:0] req1_addr,
    output logic         req1_ready,
    output logic         rsp1_valid,
    output logic [N-1:0] rsp1_data,
    output logic [A-1:0] mem_addr,
    input  logic [N-1:0] mem_q
);

    arb_state_t state, state_nxt;
    logic       last, last_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       gnt0, gnt1;

    arb_grant #(.MAX_BURST(MAX_BURST)) u_grant (
        .state     (state),
        .last      (last),
        .cnt       (cnt),
        .v0        (req0_valid),
        .v1        (req1_valid),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .state_nxt (state_nxt),
        .cnt_nxt   (cnt_nxt),
        .last_nxt  (last_nxt)
    );

    // Grants are suppressed while reset is held so nothing reaches the ROM or the response regs.
    assign req0_ready = gnt0 & ~reset;
    assign req1_ready = gnt1 & ~reset;

    // Route the winning address to the ROM; park at zero when idle.
    always_comb begin
        mem_addr = '0;
        if (req0_ready)
            mem_addr = req0_addr;
        else if (req1_ready)
            mem_addr = req1_addr;
    end

    // Arbitration state: owner, last-served side and burst length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture ROM data for whichever side won; data holds between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= req0_ready;
            rsp1_valid <= req1_ready;
            if (req0_ready)
                rsp0_data <= mem_q;
            if (req1_ready)
                rsp1_data <= mem_q;
        end
    end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 Parameter N, default 32, instruction word width in bits.
REQ-002 Parameter A, default 6, word address width (64-word ROM).
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive grants to one requester while the other waits; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0_valid  input  1  fetch requester has a read pending.
REQ-007 req0_addr  input  A  fetch word address.
REQ-008 req0_ready  output  1  fetch request granted this cycle.
REQ-009 rsp0_valid  output  1  fetch read data valid.
REQ-010 rsp0_data  output  N  fetch read data.
REQ-011 req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data SHALL mirror REQ-006..010 for the debug/loader requester.
REQ-012 mem_addr  output  A  address driven to the combinational-read imem.
REQ-013 mem_q  input  N  imem read data for mem_addr, same cycle.

Function
REQ-014 States: IDLE, OWN0, OWN1; plus last-served bit LAST and burst counter CNT, 4 bits.
REQ-015 Grant decision is combinational each cycle; at most one of req0_ready/req1_ready SHALL be high.
REQ-016 In IDLE: only one valid -> grant it; both valid -> grant requester != LAST; neither -> no grant.
REQ-017 In OWNk: owner valid and CNT < MAX_BURST -> grant owner; else other valid -> grant other; else owner valid -> grant owner with CNT restarting; else no grant.
REQ-018 Next state: grant to k -> OWNk; no grant -> IDLE.
REQ-019 CNT: grant to current owner -> CNT+1; grant to the other requester or from IDLE -> 1; no grant -> 0; CNT never exceeds MAX_BURST.
REQ-020 CNT restart per REQ-017 (owner regranted because other idle) SHALL set CNT to 1, so an owner is never blocked when alone.
REQ-021 LAST SHALL update to k on every grant to k; unchanged on no grant.
REQ-022 mem_addr SHALL equal the granted requester's address; 0 when no grant.
REQ-023 Latency exactly 1 cycle: reqk_ready high in cycle T -> rspk_valid high in T+1 with rspk_data = mem_q sampled at end of T.
REQ-024 rspk_valid SHALL be low in any cycle not following a grant to k; rspk_data holds its last value when rspk_valid low.
REQ-025 reqk_ready SHALL never assert while reqk_valid is low.
REQ-026 A requester dropping valid mid-burst SHALL release ownership that same cycle without penalty to the other.

Reset
REQ-027 reset high SHALL immediately force state IDLE, LAST=1, CNT=0, rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, independent of clk.
REQ-028 While reset is high, req0_ready=req1_ready=0 and mem_addr=0.
REQ-029 A grant issued in the cycle reset asserts SHALL produce no response; first grant after release follows REQ-016 with LAST=1 (req0 wins a tie).

Structure
REQ-030 State enum (IDLE, OWN0, OWN1) and default A, N SHALL live in a shared package imem_pkg.
REQ-031 One sub-module is natural: arb_grant, the purely combinational grant/next-state logic of REQ-015..017; registers stay in imem_arb.

Verification
REQ-032 Reset release, req0 alone addr 0..3 back-to-back -> req0_ready every cycle, rsp0_data 32'hf8000001, f8008002, f8000203, 8b050083 one cycle later each.
REQ-033 Both valid continuously from IDLE, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0,... ; never more than 4 consecutive grants to one side.
REQ-034 req1 alone addr 46 -> rsp1_valid next cycle, rsp1_data 32'hb400001f, rsp0_valid stays 0.
REQ-035 req0 valid for 10 cycles, req1 idle -> 10 consecutive grants to req0 (CNT restart), no bubbles.
REQ-036 Reset asserted asynchronously mid-burst (between clk edges) while req0 granted -> outputs clear immediately, no rsp0_valid next cycle, both valid after release -> req0 granted first.
REQ-037 Random valid/addr over 1000 cycles against ROM model -> every response data matches ROM[addr], one-hot-or-zero ready every cycle, zero errors reported.
